// File: rtl/tmr_pkg.sv
// tmr_pkg: shared health-state encoding and default thresholds for the TMR error monitor.
package tmr_pkg;
    typedef enum logic [1:0] {
        ST_OK      = 2'b00,
        ST_SUSPECT = 2'b01,
        ST_FAULT   = 2'b10
    } state_t;
    localparam int PERSIST_N_DEF = 3;
    localparam int RECOVER_N_DEF = 4;
endpackage

// File: rtl/tmr_sat_counter.sv
// tmr_sat_counter: saturating up-counter with synchronous clear and async active-low reset.
module tmr_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) count <= '0;
        else if (clr) count <= '0;
        else if (inc && count != '1) count <= count + 1'b1;
    end
endmodule

// File: rtl/tmr_error_monitor.sv
// tmr_error_monitor: registers the voted bit, counts voter disagreements and grades health OK/SUSPECT/FAULT.
module tmr_error_monitor
    import tmr_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int PERSIST_N = PERSIST_N_DEF,
    parameter int RECOVER_N = RECOVER_N_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             v_in,
    input  logic             v_error_in,
    input  logic             clr_in,
    output logic             data_out,
    output logic [CNT_W-1:0] err_count_out,
    output logic             warn_out,
    output logic             fault_out
);
    localparam logic [3:0] P_LAST = 4'(PERSIST_N - 1);
    localparam logic [3:0] R_LAST = 4'(RECOVER_N - 1);
    state_t     state, next_state;
    logic [3:0] err_run, next_err_run, clean_run, next_clean_run;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_OK;
            err_run   <= '0;
            clean_run <= '0;
            data_out  <= 1'b0;
        end else begin
            state     <= next_state;
            err_run   <= next_err_run;
            clean_run <= next_clean_run;
            data_out  <= v_in;
        end
    end
    always_comb begin
        next_state     = state;
        next_err_run   = err_run;
        next_clean_run = clean_run;
        if (clr_in) begin
            next_state     = ST_OK;
            next_err_run   = '0;
            next_clean_run = '0;
        end else begin
            case (state)
                ST_OK: if (v_error_in) begin
                    next_state     = ST_SUSPECT;
                    next_err_run   = 4'd1;
                    next_clean_run = '0;
                end
                ST_SUSPECT: if (v_error_in) begin
                    next_state     = (err_run == P_LAST) ? ST_FAULT : ST_SUSPECT;
                    next_err_run   = (err_run == P_LAST) ? '0 : err_run + 4'd1;
                    next_clean_run = '0;
                end else begin
                    next_state     = (clean_run == R_LAST) ? ST_OK : ST_SUSPECT;
                    next_err_run   = '0;
                    next_clean_run = (clean_run == R_LAST) ? '0 : clean_run + 4'd1;
                end
                ST_FAULT: ;
                default: begin
                    next_state     = ST_OK;
                    next_err_run   = '0;
                    next_clean_run = '0;
                end
            endcase
        end
    end
    // A clear discards the same-cycle error instead of counting it.
    tmr_sat_counter #(.W(CNT_W)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (v_error_in & ~clr_in),
        .clr  (clr_in),
        .count(err_count_out)
    );
    assign warn_out  = (state == ST_SUSPECT);
    assign fault_out = (state == ST_FAULT);
endmodule

// File: tb/tb_tmr_error_monitor.sv
// tb_tmr_error_monitor: randomized and directed checks of tmr_error_monitor against a behavioural model.
module tb_tmr_error_monitor;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic v_in = 1'b0, v_error_in = 1'b0, clr_in = 1'b0;
    logic data_out, warn_out, fault_out, data2, warn2, fault2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
    int n_cmp = 0;
    int n_err = 0;
    // Behavioural model: health as 0=OK 1=SUSPECT 2=FAULT plus consecutive-run lengths.
    int m_health, m_errs, m_cleans, m_cnt8, m_cnt2;
    bit m_data;

    always #5 clk = ~clk;

    tmr_error_monitor dut (
        .clk(clk), .rst(rst), .v_in(v_in), .v_error_in(v_error_in), .clr_in(clr_in),
        .data_out(data_out), .err_count_out(cnt8), .warn_out(warn_out), .fault_out(fault_out)
    );
    tmr_error_monitor #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .v_in(v_in), .v_error_in(v_error_in), .clr_in(clr_in),
        .data_out(data2), .err_count_out(cnt2), .warn_out(warn2), .fault_out(fault2)
    );

    function automatic void model_reset();
        m_health = 0; m_errs = 0; m_cleans = 0; m_cnt8 = 0; m_cnt2 = 0; m_data = 0;
    endfunction

    function automatic void model_step(bit v, bit e, bit c);
        m_data = v;
        if (c) begin
            m_health = 0; m_errs = 0; m_cleans = 0; m_cnt8 = 0; m_cnt2 = 0;
            return;
        end
        if (e) begin
            m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
            m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
        end
        if (m_health == 2) return;
        if (e) begin
            m_errs++;
            m_cleans = 0;
            if (m_errs >= 3) m_health = 2;
            else m_health = 1;
        end else if (m_health == 1) begin
            m_errs = 0;
            m_cleans++;
            if (m_cleans >= 4) begin
                m_health = 0;
                m_cleans = 0;
            end
        end
    endfunction

    function automatic logic [17:0] obs_vec();
        return {data_out, cnt8, warn_out, fault_out, data2, cnt2, warn2, fault2};
    endfunction

    function automatic logic [17:0] exp_vec();
        return {m_data, 8'(m_cnt8), m_health == 1, m_health == 2,
                m_data, 2'(m_cnt2), m_health == 1, m_health == 2};
    endfunction

    task automatic tick(bit v, bit e, bit c);
        @(negedge clk);
        v_in = v; v_error_in = e; clr_in = c;
        @(posedge clk);
        model_step(v, e, c);
        #1;
    endtask

    task automatic test_reset();
        tick(1, 1, 0);
        tick(0, 1, 0);
        @(negedge clk);
        #2;
        v_error_in = 1; v_in = 1;
        rst = 0;
        model_reset();
        #1;
        n_cmp++;
        if (obs_vec() !== 18'h0) begin
            n_err++;
            $display("FAIL reset_async obs=%h exp=%h", obs_vec(), 18'h0);
        end
        @(negedge clk);
        v_error_in = 0;
        rst = 1;
        for (int i = 0; i < 4; i++) begin
            tick(1'($urandom), 0, 0);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL reset_release[%0d] obs=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_transient();
        tick(0, 0, 1);
        tick(1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (warn_out !== 1'b1 || fault_out !== 1'b0) begin
                n_err++;
                $display("FAIL transient_warn[%0d] warn=%b fault=%b exp warn=1 fault=0", i, warn_out, fault_out);
            end
            tick(1'($urandom), 0, 0);
        end
        n_cmp++;
        if (warn_out !== 1'b0 || fault_out !== 1'b0 || cnt8 !== 8'd1) begin
            n_err++;
            $display("FAIL transient_end warn=%b fault=%b cnt=%0d exp 0 0 1", warn_out, fault_out, cnt8);
        end
    endtask

    task automatic test_persistent();
        tick(0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            tick(1'($urandom), 1, 0);
            n_cmp++;
            if (warn_out !== (i < 2) || fault_out !== (i == 2)) begin
                n_err++;
                $display("FAIL persistent[%0d] warn=%b fault=%b exp warn=%b fault=%b", i, warn_out, fault_out, i < 2, i == 2);
            end
        end
        n_cmp++;
        if (cnt8 !== 8'd3) begin
            n_err++;
            $display("FAIL persistent_cnt got=%0d exp=3", cnt8);
        end
        for (int i = 0; i < 5; i++) tick(1'($urandom), 0, 0);
        n_cmp++;
        if (fault_out !== 1'b1 || warn_out !== 1'b0) begin
            n_err++;
            $display("FAIL persistent_sticky fault=%b warn=%b exp 1 0", fault_out, warn_out);
        end
    endtask

    task automatic test_interrupted();
        bit pat [5] = '{1, 1, 0, 1, 1};
        tick(0, 0, 1);
        foreach (pat[i]) tick(1'($urandom), pat[i], 0);
        n_cmp++;
        if (fault_out !== 1'b0 || warn_out !== 1'b1 || cnt8 !== 8'd4) begin
            n_err++;
            $display("FAIL interrupted fault=%b warn=%b cnt=%0d exp 0 1 4", fault_out, warn_out, cnt8);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] exp_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        tick(0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            tick(1'($urandom), 1, 0);
            n_cmp++;
            if (cnt2 !== exp_seq[i]) begin
                n_err++;
                $display("FAIL saturation[%0d] got=%0d exp=%0d", i, cnt2, exp_seq[i]);
            end
        end
        tick(1, 1, 1);
        n_cmp++;
        if (cnt2 !== 2'd0 || cnt8 !== 8'd0 || fault2 !== 1'b0 || warn2 !== 1'b0 || data2 !== 1'b1) begin
            n_err++;
            $display("FAIL sat_clear cnt2=%0d cnt8=%0d fault=%b warn=%b data=%b exp 0 0 0 0 1", cnt2, cnt8, fault2, warn2, data2);
        end
    endtask

    task automatic test_clear_fault();
        for (int i = 0; i < 3; i++) tick(0, 1, 0);
        n_cmp++;
        if (fault_out !== 1'b1) begin
            n_err++;
            $display("FAIL clrfault_enter fault=%b exp=1", fault_out);
        end
        tick(0, 0, 1);
        n_cmp++;
        if (fault_out !== 1'b0 || warn_out !== 1'b0) begin
            n_err++;
            $display("FAIL clrfault_clear fault=%b warn=%b exp 0 0", fault_out, warn_out);
        end
        tick(0, 1, 0);
        n_cmp++;
        if (warn_out !== 1'b1 || fault_out !== 1'b0 || cnt8 !== 8'd1) begin
            n_err++;
            $display("FAIL clrfault_reenter warn=%b fault=%b cnt=%0d exp 1 0 1", warn_out, fault_out, cnt8);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            tick(1'($urandom), $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 4);
            n_cmp++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random[%0d] obs=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1;
        test_reset();
        test_transient();
        test_persistent();
        test_interrupted();
        test_saturation();
        test_clear_fault();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
